// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter/sequencer for one fixed-latency memory shared by fetch and load/store.
// Optional fetch-fairness counter is enabled with `define MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int LAT    = 2,
  parameter int FAIR_N = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // state | meaning
  // IDLE  | no transaction in flight; grants are combinational
  // ISSUE | single mem_en cycle for the latched request
  // WAIT  | counting down LAT cycles to the response
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic        own_ls_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic        fair_force;
  logic        last;

  if (LAT < 1 || LAT > 7) begin : g_lat_chk
    $error("mem_port_arbiter: LAT must be 1..7");
  end
  if (FAIR_N < 1 || FAIR_N > 7) begin : g_fair_chk
    $error("mem_port_arbiter: FAIR_N must be 1..7");
  end

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [2:0] FAIR_LIM = 3'(FAIR_N);
  logic [2:0] fair_q;

  // A flush blocks the fetch grant, so the forced turn only applies when IF can actually win.
  assign fair_force = (fair_q >= FAIR_LIM) & if_req & ls_req & ~if_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      fair_q <= 3'd0;
    end else if (ls_gnt) begin
      if (!if_req)            fair_q <= 3'd0;
      else if (fair_q != 3'd7) fair_q <= fair_q + 3'd1;
    end else if (if_gnt) begin
      fair_q <= 3'd0;
    end
  end
`else
  assign fair_force = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      drop_q   <= 1'b0;
      own_ls_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      if (ls_gnt) begin
        own_ls_q <= 1'b1;
        we_q     <= ls_we;
        addr_q   <= ls_addr;
        wdata_q  <= ls_wdata;
      end else if (if_gnt) begin
        own_ls_q <= 1'b0;
        we_q     <= 1'b0;
        addr_q   <= if_addr;
        wdata_q  <= 32'd0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    if_gnt  = 1'b0;
    ls_gnt  = 1'b0;
    mem_en  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (!rst) begin
          ls_gnt = ls_req & ~fair_force;
          if_gnt = if_req & ~if_flush & (~ls_req | fair_force);
        end
        if (ls_gnt || if_gnt) state_d = ISSUE;
      end
      ISSUE: begin
        mem_en  = ~rst;
        cnt_d   = 3'(LAT);
        state_d = WAIT;
        if (!own_ls_q && if_flush) drop_d = 1'b1;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (!own_ls_q && if_flush) drop_d = 1'b1;
        if (cnt_q <= 3'd1) begin
          last    = ~rst;
          cnt_d   = 3'd0;
          drop_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush in the completion cycle itself must also kill the fetch response.
  assign if_rvalid = last & ~own_ls_q & ~drop_q & ~if_flush;
  assign ls_rvalid = last & own_ls_q;
  assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
  assign ls_rdata  = (ls_rvalid && !we_q) ? mem_rdata : 32'd0;
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q : 32'd0;
  assign mem_wdata = mem_en ? wdata_q : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level timing model checked every cycle,
// plus literal cycle/data expectations per scenario.
module tb_mem_port_arbiter;
  localparam int LAT    = 2;
  localparam int FAIR_N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0, mem_rdata = '0;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LAT(LAT), .FAIR_N(FAIR_N)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} ls_t;

  int vectors = 0, miscompares = 0, cyc = 0;

  // requesters: hold a request until the model says it was granted
  bit          if_want = 0, ls_want = 0, ls_hold = 0;
  logic [31:0] if_w_addr = '0;
  ls_t         ls_w = '0;
  logic [31:0] if_q[$];
  ls_t         ls_q[$];

  // transaction-level model: one transaction, granted at m_g, occupies LAT+2 cycles
  bit          m_busy = 0, m_own_ls = 0, m_we = 0, m_drop = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  int          m_g = 0, next_free = 0, m_fair = 0;

  int          if_gnt_q[$], ls_gnt_q[$], if_rv_q[$], ls_rv_q[$], mem_q[$];
  logic [31:0] if_rv_d[$], ls_rv_d[$], mem_a[$], mem_d[$];
  logic        mem_w[$];

  function automatic logic [31:0] mem_func(input logic [31:0] a);
    return (a == 32'h40) ? 32'h8C22_0004 : ((a ^ 32'h3C00_0000) + 32'h11);
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    if_gnt_q.delete(); ls_gnt_q.delete(); if_rv_q.delete(); ls_rv_q.delete(); mem_q.delete();
    if_rv_d.delete(); ls_rv_d.delete(); mem_a.delete(); mem_d.delete(); mem_w.delete();
  endtask

  task automatic step(input bit flush, input bit rst_v);
    bit e_ig, e_lg, e_en, e_we, e_ir, e_lr, done, force_if;
    logic [31:0] e_ird, e_lrd, e_addr, e_wd;
    {e_ig, e_lg, e_en, e_we, e_ir, e_lr, done, force_if} = '0;
    {e_ird, e_lrd, e_addr, e_wd} = '0;
    if (!if_want && if_q.size() > 0) begin if_want = 1; if_w_addr = if_q.pop_front(); end
    if (!ls_want && ls_q.size() > 0) begin ls_want = 1; ls_w = ls_q.pop_front(); end
    rst = rst_v; if_flush = flush;
    if_req = if_want; if_addr = if_w_addr;
    ls_req = ls_want; ls_we = ls_w.we; ls_addr = ls_w.addr; ls_wdata = ls_w.wdata;
    mem_rdata = 32'hA500_0000 | 32'(cyc);
    if (rst_v) begin
      m_busy = 0; m_drop = 0; m_fair = 0; next_free = cyc + 1;
    end else begin
      if (m_busy) begin
        if (!m_own_ls && flush) m_drop = 1;
        if (cyc == m_g + 1) begin e_en = 1; e_we = m_we; e_addr = m_addr; e_wd = m_wdata; end
        if (cyc == m_g + 1 + LAT) begin
          if (!m_we) mem_rdata = mem_func(m_addr);
          if (m_own_ls) begin e_lr = 1; e_lrd = m_we ? 32'd0 : mem_rdata; end
          else if (!m_drop) begin e_ir = 1; e_ird = mem_rdata; end
          done = 1;
        end
      end
      if (cyc >= next_free) begin
`ifdef MEM_ARB_FAIRNESS_EN
        force_if = (m_fair >= FAIR_N) && if_want && ls_want && !flush;
`endif
        if (ls_want && !force_if) e_lg = 1;
        else if (if_want && !flush) e_ig = 1;
      end
    end
    @(negedge clk);
    chk("grants", {30'd0, if_gnt, ls_gnt}, {30'd0, e_ig, e_lg});
    chk("rvalids", {30'd0, if_rvalid, ls_rvalid}, {30'd0, e_ir, e_lr});
    chk("if_rdata", if_rdata, e_ird);
    chk("ls_rdata", ls_rdata, e_lrd);
    chk("mem_en_we", {30'd0, mem_en, mem_we}, {30'd0, e_en, e_we});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    if (if_gnt) if_gnt_q.push_back(cyc);
    if (ls_gnt) ls_gnt_q.push_back(cyc);
    if (if_rvalid) begin if_rv_q.push_back(cyc); if_rv_d.push_back(if_rdata); end
    if (ls_rvalid) begin ls_rv_q.push_back(cyc); ls_rv_d.push_back(ls_rdata); end
    if (mem_en) begin
      mem_q.push_back(cyc); mem_a.push_back(mem_addr); mem_d.push_back(mem_wdata); mem_w.push_back(mem_we);
    end
    if (done) begin m_busy = 0; m_drop = 0; end
    if (e_lg) begin
      m_busy = 1; m_own_ls = 1; m_we = ls_w.we; m_addr = ls_w.addr; m_wdata = ls_w.wdata;
      m_g = cyc; next_free = cyc + LAT + 2;
      m_fair = if_want ? ((m_fair < 7) ? m_fair + 1 : 7) : 0;
      ls_want = ls_hold;
    end else if (e_ig) begin
      m_busy = 1; m_own_ls = 0; m_we = 0; m_addr = if_w_addr; m_wdata = 0;
      m_g = cyc; next_free = cyc + LAT + 2; m_fair = 0;
      if_want = 0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(input int n, input int f_lo, input int f_hi, input int r_at);
    for (int i = 0; i < n; i++) step(cyc >= f_lo && cyc <= f_hi, cyc == r_at);
  endtask

  int base;

  initial begin
    @(posedge clk); #1;
    step(0, 1);
    step(0, 1);

    // fetch-only, back-to-back fetches
    clear_logs(); base = cyc;
    if_q.push_back(32'h40); if_q.push_back(32'h44);
    run(9, -1, -1, -1);
    chk("A_if_gnt0", qget(if_gnt_q, 0), base);
    chk("A_mem_cyc", qget(mem_q, 0), base + 1);
    chk("A_mem_addr", mem_a[0], 32'h40);
    chk("A_if_rv_cyc", qget(if_rv_q, 0), base + 3);
    chk("A_if_rdata", if_rv_d[0], 32'h8C22_0004);
    chk("A_if_gnt1", qget(if_gnt_q, 1), base + 4);

    // store
    clear_logs(); base = cyc;
    ls_q.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'hDEAD_BEEF});
    run(5, -1, -1, -1);
    chk("B_ls_gnt", qget(ls_gnt_q, 0), base);
    chk("B_mem_cyc", qget(mem_q, 0), base + 1);
    chk("B_mem_we", {31'd0, mem_w[0]}, 32'd1);
    chk("B_mem_addr", mem_a[0], 32'h100);
    chk("B_mem_wdata", mem_d[0], 32'hDEAD_BEEF);
    chk("B_ls_rv_cyc", qget(ls_rv_q, 0), base + 3);
    chk("B_ls_rdata", ls_rv_d[0], 32'd0);

    // contention: LS first, fetch after
    clear_logs(); base = cyc;
    if_q.push_back(32'h80);
    ls_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h1234_5678});
    run(9, -1, -1, -1);
    chk("C_ls_gnt", qget(ls_gnt_q, 0), base);
    chk("C_if_gnt", qget(if_gnt_q, 0), base + 4);
    chk("C_if_rv_cyc", qget(if_rv_q, 0), base + 7);
    chk("C_ls_rdata", ls_rv_d[0], 32'h3C00_0211);
    chk("C_if_rdata", if_rv_d[0], 32'h3C00_0091);

    // flush mid-WAIT drops the first fetch
    clear_logs(); base = cyc;
    if_q.push_back(32'h48); if_q.push_back(32'h4C);
    run(9, base + 2, base + 2, -1);
    chk("D_if_gnt1", qget(if_gnt_q, 1), base + 4);
    chk("D_if_rv_cyc", qget(if_rv_q, 0), base + 7);
    chk("D_if_rv_cnt", if_rv_q.size(), 1);

    // flush on the rvalid cycle, then again in IDLE with a fetch pending
    clear_logs(); base = cyc;
    if_q.push_back(32'h50); if_q.push_back(32'h54);
    run(10, base + 3, base + 4, -1);
    chk("E_if_gnt1", qget(if_gnt_q, 1), base + 5);
    chk("E_if_rv_cyc", qget(if_rv_q, 0), base + 8);

    // both requests held: fairness (or strict LS priority)
    clear_logs(); base = cyc;
    ls_hold = 1;
    ls_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
    if_q.push_back(32'h60);
    run(17, -1, -1, -1);
    ls_hold = 0;
    run(12, -1, -1, -1);
    chk("F_ls_gnt0", qget(ls_gnt_q, 0), base);
    chk("F_ls_gnt1", qget(ls_gnt_q, 1), base + 4);
    chk("F_ls_gnt2", qget(ls_gnt_q, 2), base + 8);
    chk("F_ls_gnt3", qget(ls_gnt_q, 3), base + 12);
`ifdef MEM_ARB_FAIRNESS_EN
    chk("F_if_gnt_fair", qget(if_gnt_q, 0), base + 16);
`else
    chk("F_ls_gnt4", qget(ls_gnt_q, 4), base + 16);
    chk("F_if_gnt_late", qget(if_gnt_q, 0), base + 24);
`endif

    // reset in the middle of a load; next pending load granted right after
    clear_logs(); base = cyc;
    ls_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0});
    ls_q.push_back('{we: 1'b0, addr: 32'h404, wdata: 32'h0});
    run(8, -1, -1, base + 2);
    chk("G_ls_gnt1", qget(ls_gnt_q, 1), base + 3);
    chk("G_mem_cyc1", qget(mem_q, 1), base + 4);
    chk("G_ls_rv_cyc", qget(ls_rv_q, 0), base + 6);
    chk("G_ls_rv_cnt", ls_rv_q.size(), 1);
    chk("G_ls_rdata", ls_rv_d[0], 32'h3C00_0415);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
